// File: rtl/alu_operand_sequencer.sv
// Front-end for alu_controller: collects operand A then operand B from a
// byte stream, fires a one-cycle start, waits (bounded) for done, and
// presents the result or a timeout error on a valid/ready result port.
module alu_operand_sequencer #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_done,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_B,
    S_START,
    S_WAIT_DONE,
    S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              xfer;

  // Every handshake output is a pure decode of the state register, so no
  // input can reach an output combinationally.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_GET_B);
  assign alu_start = (state_q == S_START);
  assign res_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = res_q;
  assign res_err   = err_q;

  assign xfer    = in_valid && in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and datapath update; operands only move while accepting input.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          a_d     = in_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (xfer) begin
          b_d     = in_data;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // done is deliberately not looked at while start is asserted
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (alu_done) begin
          // done beats a timeout landing on the same edge
          res_d   = alu_c;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and drops any
  // transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized transaction-level bench for alu_operand_sequencer; the bench
// plays the alu_controller role and predicts result, error and latency.
module tb_alu_operand_sequencer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_start;
  logic [7:0] alu_c;
  logic       alu_done;
  logic [7:0] res_data;
  logic       res_err;
  logic       res_valid;
  logic       res_ready;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_operand_sequencer #(
    .DATA_W        (8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_start(alu_start),
    .alu_c    (alu_c),
    .alu_done (alu_done),
    .res_data (res_data),
    .res_err  (res_err),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete transaction. done_at is the WAIT_DONE cycle (1-based) in
  // which the bench raises alu_done, 0 for never; start_done raises done
  // during the start cycle only.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input int done_at, input bit start_done, input int gap, input int hold);
    bit         exp_err;
    int         exp_lat;
    logic [7:0] exp_res;
    int         lat;
    bit         seen;

    // Reference: a done inside the wait budget yields C after done_at+1
    // cycles from start; otherwise an error result after T+1 cycles.
    exp_err = (done_at < 1) || (done_at > T);
    exp_lat = exp_err ? T + 1 : done_at + 1;
    exp_res = exp_err ? 8'h00 : c;

    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    check_eq("a_latched", 32'(alu_a), 32'(a));
    check_eq("getb_in_ready", 32'(in_ready), 32'd1);
    check_eq("getb_no_start", 32'(alu_start), 32'd0);

    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) begin
      tick();
      check_eq("getb_wait_no_start", 32'(alu_start), 32'd0);
      check_eq("getb_wait_ready", 32'(in_ready), 32'd1);
    end

    in_valid = 1'b1;
    in_data  = b;
    tick();
    check_eq("start_pulse", 32'(alu_start), 32'd1);
    check_eq("b_latched", 32'(alu_b), 32'(b));
    check_eq("a_held_start", 32'(alu_a), 32'(a));
    check_eq("start_in_ready", 32'(in_ready), 32'd0);

    alu_done = start_done;
    alu_c    = 8'($urandom);
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= T + 3 && !seen; k++) begin
      tick();
      if (res_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        check_eq("wait_no_start", 32'(alu_start), 32'd0);
        check_eq("wait_ops_held", 32'({alu_a, alu_b}), 32'({a, b}));
        check_eq("wait_in_ready", 32'(in_ready), 32'd0);
        alu_done = (k == done_at);
        alu_c    = (k == done_at) ? c : 8'($urandom);
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
    end
    alu_done = 1'b0;
    check_eq("result_latency", 32'(lat), 32'(exp_lat));
    check_eq("res_data", 32'(res_data), 32'(exp_res));
    check_eq("res_err", 32'(res_err), 32'(exp_err));
    check_eq("out_busy", 32'(busy), 32'd1);

    res_ready = 1'b0;
    repeat (hold) begin
      in_valid = 1'b1;
      in_data  = ~in_data;
      tick();
      check_eq("bp_res_valid", 32'(res_valid), 32'd1);
      check_eq("bp_res_stable", 32'({res_err, res_data}), 32'({exp_err, exp_res}));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_no_start", 32'(alu_start), 32'd0);
      check_eq("bp_ops_held", 32'({alu_a, alu_b}), 32'({a, b}));
    end

    res_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_hs_res_valid", 32'(res_valid), 32'd0);
    check_eq("post_hs_busy", 32'(busy), 32'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    res_ready = 1'b0;
    alu_done  = 1'b0;
    alu_c     = 8'h00;

    repeat (2) begin
      tick();
      check_eq("rst_no_start", 32'(alu_start), 32'd0);
    end
    check_eq("rst_ops", 32'({alu_a, alu_b}), 32'd0);
    check_eq("rst_res", 32'({res_valid, res_err, res_data}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_eq("rst_release_ready", 32'(in_ready), 32'd1);
    check_eq("rst_release_start", 32'(alu_start), 32'd0);
    check_eq("rst_release_busy", 32'(busy), 32'd0);

    // Normal op, done three cycles after start
    run_txn(8'h12, 8'h34, 8'h46, 3, 1'b0, 0, 1);
    // Timeout
    run_txn(8'h01, 8'h02, 8'h03, 0, 1'b0, 0, 0);
    // done coincides with the counter limit
    run_txn(8'hC3, 8'h3C, 8'h5E, T, 1'b0, 1, 0);
    // done only during the start cycle
    run_txn(8'h77, 8'h88, 8'h99, 0, 1'b1, 0, 0);
    // done one cycle too late
    run_txn(8'h10, 8'h20, 8'h30, T + 1, 1'b0, 0, 0);
    // back-pressure for 10 cycles
    run_txn(8'hA1, 8'hB2, 8'hC4, 1, 1'b0, 2, 10);

    // Reset while waiting for done, then a late done must be ignored
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    check_eq("mid_rst_start", 32'(alu_start), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ops", 32'({alu_a, alu_b}), 32'd0);
    alu_done = 1'b1;
    alu_c    = 8'h99;
    repeat (3) begin
      tick();
      check_eq("mid_rst_no_valid", 32'(res_valid), 32'd0);
      check_eq("mid_rst_no_start", 32'(alu_start), 32'd0);
      check_eq("mid_rst_idle", 32'(busy), 32'd0);
    end
    alu_done = 1'b0;
    run_txn(8'hFF, 8'h01, 8'h00, 2, 1'b0, 0, 0);

    // Randomized transactions
    for (int i = 0; i < 25; i++) begin
      int idle;
      idle = int'($urandom_range(0, 2));
      repeat (idle) tick();
      run_txn(8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, T + 1)), 1'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
